uov_result_serializer: RTL and testbench

Downstream of the `uov` core: captures the wide result bundle when `done` rises and streams it out as a byte-wide valid/ready frame to the host link. It emits bytes in the same order the host prints results: lowest byte of each field first. Frame content is selected by the mode that ran (keygen, sign or verify).

---
 rtl/uov_ser_pkg.sv | 19 +
 rtl/uov_result_serializer.sv | 109 ++++++++++
 tb/tb_uov_result_serializer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uov_ser_pkg.sv
// uov_ser_pkg: states, mode codes and frame lengths shared by uov_result_serializer.
// TRAIL state is present only when SER_CYCLES_EN is defined.
package uov_ser_pkg;
    typedef enum logic [1:0] {
        IDLE,
        SEND
`ifdef SER_CYCLES_EN
        , TRAIL
`endif
    } state_t;

    localparam logic [2:0] MODE_KEYGEN = 3'd0;
    localparam logic [2:0] MODE_SIGN   = 3'd1;
    localparam logic [2:0] MODE_VRFY   = 3'd2;

    localparam int PK_SEED_BYTES = 16;
    localparam int SALT_BYTES    = 16;
    localparam int CYC_BYTES     = 4;
endpackage

// File: rtl/uov_result_serializer.sv
// uov_result_serializer: captures the uov result bundle on a done rise and streams it LSB byte first.
// SER_CYCLES_EN appends a 4-byte cycle-count trailer after the payload.
module uov_result_serializer
    import uov_ser_pkg::*;
#(
    parameter int GF_BIT = 8,
    parameter int V      = 68,
    parameter int O      = 44,
    parameter int RES_W  = GF_BIT * (V + O)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic             done,
    input  logic [RES_W-1:0] result_in,
    input  logic [127:0]     sig_rand_in,
    input  logic [30:0]      cycles_in,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             overrun
);
    localparam int SR_W = RES_W + 128;
    localparam int CW   = $clog2(RES_W / 8 + SALT_BYTES + 1);

    state_t          state_q;
    logic            done_q;
    logic [SR_W-1:0] sr_q;
    logic [CW-1:0]   rem_q;
    logic            ovr_q;
    logic            rise;

    assign rise    = done & ~done_q;
    assign m_valid = state_q != IDLE;
    assign busy    = state_q != IDLE;
    assign overrun = ovr_q;

`ifdef SER_CYCLES_EN
    logic [31:0] cyc_q;

    assign m_data = (state_q == TRAIL) ? cyc_q[7:0] : sr_q[7:0];
    assign m_last = (state_q == TRAIL) && (rem_q == CW'(1));
`else
    logic unused_cycles;

    assign unused_cycles = ^cycles_in;
    assign m_data = sr_q[7:0];
    assign m_last = (state_q == SEND) && (rem_q == CW'(1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            sr_q    <= '0;
            rem_q   <= '0;
            ovr_q   <= 1'b0;
`ifdef SER_CYCLES_EN
            cyc_q   <= '0;
`endif
        end else begin
            done_q <= done;
            // a rise outside IDLE (including on the final handshake) is dropped but remembered
            if (rise && state_q != IDLE) ovr_q <= 1'b1;
            case (state_q)
                IDLE: if (rise) begin
`ifdef SER_CYCLES_EN
                    cyc_q <= {1'b0, cycles_in};
`endif
                    if (mode == MODE_KEYGEN) begin
                        sr_q    <= SR_W'(result_in[127:0]);
                        rem_q   <= CW'(PK_SEED_BYTES);
                        state_q <= SEND;
                    end else if (mode == MODE_SIGN) begin
                        sr_q    <= {sig_rand_in, result_in};
                        rem_q   <= CW'(RES_W / 8 + SALT_BYTES);
                        state_q <= SEND;
                    end else if (mode == MODE_VRFY) begin
                        sr_q    <= SR_W'(result_in[0]);
                        rem_q   <= CW'(1);
                        state_q <= SEND;
                    end
                end
                SEND: if (m_ready) begin
                    sr_q  <= sr_q >> 8;
                    rem_q <= rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
`ifdef SER_CYCLES_EN
                        rem_q   <= CW'(CYC_BYTES);
                        state_q <= TRAIL;
`else
                        state_q <= IDLE;
`endif
                    end
                end
`ifdef SER_CYCLES_EN
                TRAIL: if (m_ready) begin
                    cyc_q <= cyc_q >> 8;
                    rem_q <= rem_q - CW'(1);
                    if (rem_q == CW'(1)) state_q <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uov_result_serializer.sv
// tb_uov_result_serializer: random-stimulus bench comparing the byte stream against a queue-based frame model.
module tb_uov_result_serializer;
    localparam int RES_W = 896;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       mode = 3'd0;
    logic             done = 1'b0;
    logic [RES_W-1:0] result_in = '0;
    logic [127:0]     sig_rand_in = '0;
    logic [30:0]      cycles_in = '0;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic             m_last;
    logic             busy;
    logic             overrun;

    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];

    uov_result_serializer dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .done(done), .result_in(result_in),
        .sig_rand_in(sig_rand_in), .cycles_in(cycles_in), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    // expected frame built straight from the byte-order rules
    task automatic model(input logic [2:0] md);
        logic [31:0] cc;
        cc = {1'b0, cycles_in};
        exp_q.delete();
        if (md == 3'd0) for (int k = 0; k < 16; k++) exp_q.push_back(result_in[8*k +: 8]);
        if (md == 3'd1) begin
            for (int k = 0; k < RES_W / 8; k++) exp_q.push_back(result_in[8*k +: 8]);
            for (int k = 0; k < 16; k++) exp_q.push_back(sig_rand_in[8*k +: 8]);
        end
        if (md == 3'd2) exp_q.push_back({7'b0, result_in[0]});
`ifdef SER_CYCLES_EN
        if (md < 3'd3) for (int k = 0; k < 4; k++) exp_q.push_back(cc[8*k +: 8]);
`endif
    endtask

    task automatic randomize_inputs();
        for (int w = 0; w < RES_W / 32; w++) result_in[32*w +: 32] = $urandom();
        for (int w = 0; w < 4; w++) sig_rand_in[32*w +: 32] = $urandom();
        cycles_in = 31'($urandom());
    endtask

    task automatic launch(input logic [2:0] md);
        @(negedge clk);
        mode = md;
        model(md);
        chk("idle_before_rise", {63'b0, m_valid}, 64'd0);
        done = 1'b1;
    endtask

    // pulse_at: byte index at which done rises again; stop_at: abandon frame at this byte
    task automatic recv(input bit rnd, input int pulse_at, input int stop_at);
        int i = 0;
        int cyc = 0;
        int n = exp_q.size();
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [7:0] pd = 8'h00;
        while (i < n && i != stop_at && cyc < 3000) begin
            @(negedge clk);
            done = (pulse_at >= 0 && i >= pulse_at) ? 1'b1 : 1'b0;
            if (cyc == 0) chk("first_valid_latency", {63'b0, m_valid}, 64'd1);
            if (pv && !pr) chk("stall_stable", {54'b0, m_valid, m_last, m_data}, {54'b0, 1'b1, pl, pd});
            m_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (m_valid && m_ready) begin
                chk($sformatf("data[%0d]", i), {56'b0, m_data}, {56'b0, exp_q[i]});
                chk($sformatf("last[%0d]", i), {63'b0, m_last}, {63'b0, i == n - 1});
                i++;
            end
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
            cyc++;
        end
        if (cyc >= 3000) chk("frame_timeout", 64'(i), 64'(n));
        if (i == n) begin
            @(negedge clk);
            chk("valid_drops", {62'b0, m_valid, busy}, 64'd0);
        end
    endtask

    initial begin
        int nv;
        #1;
        chk("reset_outputs", {52'b0, m_data, m_valid, m_last, busy, overrun}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) result_in[8*k +: 8] = 8'(k);
        cycles_in = 31'h12345678;
        launch(3'd0);
        recv(1'b0, -1, -1);

        for (int k = 0; k < RES_W / 8; k++) result_in[8*k +: 8] = 8'(k);
        for (int k = 0; k < 16; k++) sig_rand_in[8*k +: 8] = 8'(8'hA0 + k);
        launch(3'd1);
        recv(1'b1, -1, -1);

        result_in[0] = 1'b1;
        launch(3'd2);
        recv(1'b1, -1, -1);
        result_in[0] = 1'b0;
        launch(3'd2);
        recv(1'b1, -1, -1);
        chk("no_overrun_yet", {63'b0, overrun}, 64'd0);

        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            mode = 3'($urandom_range(3, 7));
            done = 1'b1;
            nv = 0;
            repeat (8) begin
                @(negedge clk);
                nv += int'(m_valid);
            end
            done = 1'b0;
            chk("bad_mode_ignored", {31'b0, overrun, nv}, 64'd0);
        end

        for (int t = 0; t < 6; t++) begin
            randomize_inputs();
            launch(3'($urandom_range(0, 2)));
            recv(1'b1, -1, -1);
        end

        randomize_inputs();
        launch(3'd1);
        recv(1'b1, 5, -1);
        chk("overrun_set", {63'b0, overrun}, 64'd1);
        nv = 0;
        repeat (50) begin
            @(negedge clk);
            nv += int'(m_valid);
        end
        chk("held_done_one_frame", 64'(nv), 64'd0);
        done = 1'b0;
        randomize_inputs();
        launch(3'd0);
        recv(1'b1, -1, -1);
        chk("overrun_sticky", {63'b0, overrun}, 64'd1);

        randomize_inputs();
        launch(3'd1);
        recv(1'b1, -1, 40);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_frame", {52'b0, m_data, m_valid, m_last, busy, overrun}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        randomize_inputs();
        launch(3'd0);
        recv(1'b1, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
